cache_line_fill_ctrl: RTL and testbench

- Memory-side refill/writeback engine directly downstream of the 4-way SA_Cache.
- On a cache miss it optionally writes back the dirty victim line, then fetches the missing line.
- Both transfers run as MEM_DATA_WIDTH-wide beats on a narrow memory bus.
- The fetched line is returned to the cache on o_memory_line together with a one-cycle o_memory_response pulse, matching the cache's i_memory_line / i_memory_response inputs.

---
 rtl/cache_pkg.sv | 21 ++
 rtl/line_beat_assembler.sv | 37 +++
 rtl/cache_line_fill_ctrl.sv | 149 ++++++++++++++
 tb/tb_cache_line_fill_ctrl.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and helpers for the cache refill/writeback path.
// Constants here describe the default geometry (64-byte line, 32-bit beats).
package cache_pkg;

  localparam int LINE_SIZE_BITS = 64 * 8;
  localparam int BEATS          = LINE_SIZE_BITS / 32;
  localparam int BEAT_BYTES     = 32 / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    RESP = 2'd3
  } fill_state_e;

  // Clear the line-offset field of a byte address (up to 64 bits wide).
  function automatic logic [63:0] line_align(input logic [63:0] addr, input int off_bits);
    return addr & ~((64'd1 << off_bits) - 64'd1);
  endfunction

endpackage

// File: rtl/line_beat_assembler.sv
// Collects narrow data words into a wide line register, lowest word first.
// A collect counter selects the destination word and stops counting via the caller's enable.
module line_beat_assembler #(
  parameter int WORD_W = 32,
  parameter int WORDS  = 16,
  parameter int CNT_W  = $clog2(WORDS) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      wr_en,
  input  logic [WORD_W-1:0]         wdata,
  output logic [WORDS*WORD_W-1:0]   line,
  output logic [CNT_W-1:0]          cnt,
  output logic                      last
);

  localparam int IDX_W = $clog2(WORDS);

  logic [WORDS-1:0][WORD_W-1:0] words_q;

  assign line = words_q;
  assign last = wr_en && (cnt == CNT_W'(WORDS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      words_q <= '0;
      cnt     <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (wr_en) begin
      words_q[cnt[IDX_W-1:0]] <= wdata;
      cnt                     <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cache_line_fill_ctrl.sv
// Miss engine between the set-associative cache and a narrow memory bus:
// optional dirty-victim writeback, then a pipelined line fill returned with a one-cycle pulse.
module cache_line_fill_ctrl
  import cache_pkg::*;
#(
  parameter int LINE_SIZE_BYTES = 64,
  parameter int ADDRESS_WIDTH   = 32,
  parameter int OFFSET_BITS     = 6,
  parameter int MEM_DATA_WIDTH  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_miss_req,
  input  logic [ADDRESS_WIDTH-1:0]     i_miss_addr,
  input  logic                         i_evict,
  input  logic [ADDRESS_WIDTH-1:0]     i_evict_addr,
  input  logic [LINE_SIZE_BYTES*8-1:0] i_evict_data,
  output logic [LINE_SIZE_BYTES*8-1:0] o_memory_line,
  output logic                         o_memory_response,
  output logic                         o_busy,
  output logic                         o_mem_req,
  output logic                         o_mem_we,
  output logic [ADDRESS_WIDTH-1:0]     o_mem_addr,
  output logic [MEM_DATA_WIDTH-1:0]    o_mem_wdata,
  input  logic                         i_mem_ready,
  input  logic                         i_mem_rvalid,
  input  logic [MEM_DATA_WIDTH-1:0]    i_mem_rdata
);

  localparam int LINE_W  = LINE_SIZE_BYTES * 8;
  localparam int N_BEATS = LINE_W / MEM_DATA_WIDTH;
  localparam int BEAT_B  = MEM_DATA_WIDTH / 8;
  localparam int CNT_W   = $clog2(N_BEATS) + 1;
  localparam int IDX_W   = $clog2(N_BEATS);

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BEATS - 1);
  localparam logic [CNT_W-1:0] ALL_BEATS = CNT_W'(N_BEATS);

  fill_state_e state_q, state_d;

  logic [ADDRESS_WIDTH-1:0]                    base_q;
  logic [ADDRESS_WIDTH-1:0]                    victim_addr_q;
  logic [N_BEATS-1:0][MEM_DATA_WIDTH-1:0]      victim_q;
  logic [CNT_W-1:0]                            wcnt_q;
  logic [CNT_W-1:0]                            icnt_q;
  logic [CNT_W-1:0]                            ccnt;
  logic                                        capture;
  logic                                        hs;
  logic                                        col_en;
  logic                                        col_last;

  function automatic logic [ADDRESS_WIDTH-1:0] align(input logic [ADDRESS_WIDTH-1:0] a);
    return ADDRESS_WIDTH'(line_align(64'(a), OFFSET_BITS));
  endfunction

  function automatic logic [ADDRESS_WIDTH-1:0] beat_offset(input logic [CNT_W-1:0] n);
    return ADDRESS_WIDTH'(n) * ADDRESS_WIDTH'(BEAT_B);
  endfunction

  assign capture = (state_q == IDLE) && i_miss_req;
  assign hs      = o_mem_req && i_mem_ready;
  // Late or stray read data is dropped once the line is complete or outside a fill.
  assign col_en  = (state_q == FILL) && i_mem_rvalid && (ccnt < ALL_BEATS);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      base_q        <= '0;
      victim_addr_q <= '0;
      victim_q      <= '0;
      wcnt_q        <= '0;
      icnt_q        <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        base_q <= align(i_miss_addr);
        wcnt_q <= '0;
        icnt_q <= '0;
        if (i_evict) begin
          victim_addr_q <= align(i_evict_addr);
          victim_q      <= i_evict_data;
        end
      end
      if ((state_q == WB) && hs) begin
        wcnt_q <= wcnt_q + CNT_W'(1);
      end
      if ((state_q == FILL) && hs) begin
        icnt_q <= icnt_q + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d           = state_q;
    o_mem_req         = 1'b0;
    o_mem_we          = 1'b0;
    o_mem_addr        = '0;
    o_mem_wdata       = '0;
    o_memory_response = 1'b0;
    o_busy            = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (i_miss_req) begin
          state_d = i_evict ? WB : FILL;
        end
      end
      WB: begin
        o_mem_req   = 1'b1;
        o_mem_we    = 1'b1;
        o_mem_addr  = victim_addr_q + beat_offset(wcnt_q);
        o_mem_wdata = victim_q[wcnt_q[IDX_W-1:0]];
        if (i_mem_ready && (wcnt_q == LAST_BEAT)) begin
          state_d = FILL;
        end
      end
      FILL: begin
        // Issue runs ahead of collection; reads stay outstanding without limit.
        if (icnt_q < ALL_BEATS) begin
          o_mem_req  = 1'b1;
          o_mem_addr = base_q + beat_offset(icnt_q);
        end
        if (col_last) begin
          state_d = RESP;
        end
      end
      RESP: begin
        o_memory_response = 1'b1;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  line_beat_assembler #(
    .WORD_W (MEM_DATA_WIDTH),
    .WORDS  (N_BEATS),
    .CNT_W  (CNT_W)
  ) u_assembler (
    .clk   (clk),
    .rst   (rst),
    .clear (capture),
    .wr_en (col_en),
    .wdata (i_mem_rdata),
    .line  (o_memory_line),
    .cnt   (ccnt),
    .last  (col_last)
  );

endmodule

// File: tb/tb_cache_line_fill_ctrl.sv
// Scoreboard bench: a bus-side memory model checks every beat against queued expectations
// and each response pulse against the queued expected line.
module tb_cache_line_fill_ctrl;
  import cache_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = LINE_SIZE_BITS;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_miss_req = 1'b0;
  logic [AW-1:0] i_miss_addr = '0;
  logic          i_evict = 1'b0;
  logic [AW-1:0] i_evict_addr = '0;
  logic [LW-1:0] i_evict_data = '0;
  logic [LW-1:0] o_memory_line;
  logic          o_memory_response;
  logic          o_busy;
  logic          o_mem_req;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic          i_mem_ready = 1'b0;
  logic          i_mem_rvalid = 1'b0;
  logic [DW-1:0] i_mem_rdata = '0;

  always #5 clk = ~clk;

  cache_line_fill_ctrl dut (
    .clk               (clk),
    .rst               (rst),
    .i_miss_req        (i_miss_req),
    .i_miss_addr       (i_miss_addr),
    .i_evict           (i_evict),
    .i_evict_addr      (i_evict_addr),
    .i_evict_data      (i_evict_data),
    .o_memory_line     (o_memory_line),
    .o_memory_response (o_memory_response),
    .o_busy            (o_busy),
    .o_mem_req         (o_mem_req),
    .o_mem_we          (o_mem_we),
    .o_mem_addr        (o_mem_addr),
    .o_mem_wdata       (o_mem_wdata),
    .i_mem_ready       (i_mem_ready),
    .i_mem_rvalid      (i_mem_rvalid),
    .i_mem_rdata       (i_mem_rdata)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } beat_t;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rsp_t;

  beat_t         wr_exp_q[$];
  logic [AW-1:0] rd_exp_q[$];
  logic [LW-1:0] line_exp_q[$];
  rsp_t          rsp_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ready_mode = 0;
  int lat_mode = 0;
  int pat_idx = 0;
  bit spur = 1'b0;
  int wr_cnt = 0;
  int resp_cnt = 0;
  int resp_cyc = 0;
  logic [AW-1:0] fill_base = '0;
  logic [DW-1:0] rd_base = '0;
  logic [LW-1:0] last_line = '0;
  bit            prev_stall = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [DW-1:0] prev_wdata = '0;

  task automatic check_eq(input string tag, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < BEATS; k++) v[k*DW +: DW] = $urandom;
    return v;
  endfunction

  initial forever @(posedge clk) cyc++;

  // Memory agent and output monitor, evaluated once per cycle on the falling edge.
  initial begin
    beat_t e;
    rsp_t  r;
    int    k;
    int    due;
    forever begin
      @(negedge clk);
      i_mem_rvalid = 1'b0;
      i_mem_rdata  = '0;
      if (spur) begin
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 32'hDEAD_BEEF;
      end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
        r = rsp_q.pop_front();
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = r.data;
      end
      if (ready_mode == 1) begin
        i_mem_ready = ((pat_idx % 4) == 0) || ((pat_idx % 4) == 3);
        pat_idx++;
      end else begin
        i_mem_ready = 1'b1;
      end
      if (prev_stall && o_mem_req) begin
        check_eq("stall_addr", LW'(o_mem_addr), LW'(prev_addr));
        check_eq("stall_wdata", LW'(o_mem_wdata), LW'(prev_wdata));
      end
      prev_stall = o_mem_req && !i_mem_ready;
      prev_addr  = o_mem_addr;
      prev_wdata = o_mem_wdata;
      if (o_mem_req && i_mem_ready) begin
        if (o_mem_we) begin
          wr_cnt++;
          if (wr_exp_q.size() == 0) begin
            check_eq("wr_unexpected", LW'(o_mem_addr), LW'(32'hFFFF_FFFF));
          end else begin
            e = wr_exp_q.pop_front();
            check_eq("wr_addr", LW'(o_mem_addr), LW'(e.addr));
            check_eq("wr_data", LW'(o_mem_wdata), LW'(e.data));
          end
        end else begin
          check_eq("wr_before_rd", LW'(wr_exp_q.size()), LW'(0));
          if (rd_exp_q.size() == 0) begin
            check_eq("rd_unexpected", LW'(o_mem_addr), LW'(32'hFFFF_FFFF));
          end else begin
            check_eq("rd_addr", LW'(o_mem_addr), LW'(rd_exp_q.pop_front()));
          end
          k   = int'((o_mem_addr - fill_base) >> 2);
          due = cyc + ((lat_mode == 1) ? int'($urandom_range(5, 1)) : 1);
          if (rsp_q.size() > 0 && due <= rsp_q[$].due) due = rsp_q[$].due + 1;
          rsp_q.push_back('{due: due, data: rd_base + DW'(k)});
        end
      end
      if (o_memory_response) begin
        resp_cnt++;
        resp_cyc = cyc;
        if (line_exp_q.size() == 0) begin
          check_eq("resp_unexpected", LW'(o_memory_response), LW'(0));
        end else begin
          check_eq("resp_line", o_memory_line, line_exp_q.pop_front());
        end
      end
    end
  end

  task automatic start_miss(input logic [AW-1:0] maddr, input bit ev, input logic [AW-1:0] eaddr,
                            input logic [LW-1:0] edata, input logic [DW-1:0] rbase, output int start);
    logic [AW-1:0] b;
    logic [AW-1:0] vb;
    logic [LW-1:0] line;
    b  = maddr & 32'hFFFF_FFC0;
    vb = eaddr & 32'hFFFF_FFC0;
    @(negedge clk);
    fill_base = b;
    rd_base   = rbase;
    resp_cnt  = 0;
    wr_cnt    = 0;
    if (ev) begin
      for (int k = 0; k < BEATS; k++) wr_exp_q.push_back('{addr: vb + AW'(k * 4), data: edata[k*DW +: DW]});
    end
    for (int k = 0; k < BEATS; k++) begin
      rd_exp_q.push_back(b + AW'(k * 4));
      line[k*DW +: DW] = rbase + DW'(k);
    end
    line_exp_q.push_back(line);
    last_line    = line;
    i_miss_req   = 1'b1;
    i_miss_addr  = maddr;
    i_evict      = ev;
    i_evict_addr = eaddr;
    i_evict_data = edata;
    start        = cyc;
    @(negedge clk);
    // Captured values must not be re-read after the request cycle.
    i_miss_addr  = $urandom;
    i_evict_addr = $urandom;
    i_evict      = 1'($urandom);
    i_evict_data = rand_line();
  endtask

  task automatic wait_resp(input string tag, input int start, input int exp_lat);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 2000) begin
      @(negedge clk);
      n++;
      if (o_memory_response) seen = 1'b1;
    end
    i_miss_req = 1'b0;
    if (!seen) check_eq({tag, "_timeout"}, LW'(0), LW'(1));
    repeat (3) @(negedge clk);
    check_eq({tag, "_resp_count"}, LW'(resp_cnt), LW'(1));
    if (exp_lat >= 0) check_eq({tag, "_latency"}, LW'(resp_cyc - start), LW'(exp_lat));
    check_eq({tag, "_wr_left"}, LW'(wr_exp_q.size()), LW'(0));
    check_eq({tag, "_rd_left"}, LW'(rd_exp_q.size()), LW'(0));
    check_eq({tag, "_idle"}, LW'(o_busy), LW'(0));
  endtask

  initial begin
    int            s;
    int            n;
    logic [LW-1:0] vdata;

    repeat (3) @(negedge clk);
    check_eq("rst_req", LW'(o_mem_req), LW'(0));
    check_eq("rst_busy", LW'(o_busy), LW'(0));
    check_eq("rst_addr", LW'(o_mem_addr), LW'(0));
    check_eq("rst_resp", LW'(o_memory_response), LW'(0));
    check_eq("rst_line", o_memory_line, LW'(0));
    rst = 1'b0;

    start_miss(32'h0000_1234, 1'b0, '0, '0, 32'h0000_00A0, s);
    wait_resp("clean", s, 18);

    for (int k = 0; k < BEATS; k++) vdata[k*DW +: DW] = 32'h1000_0000 + DW'(k);
    start_miss(32'h0000_0100, 1'b1, 32'h0000_8040, vdata, $urandom, s);
    wait_resp("dirty", s, 34);

    ready_mode = 1;
    start_miss($urandom, 1'b1, $urandom, rand_line(), $urandom, s);
    wait_resp("backpressure", s, -1);
    ready_mode = 0;

    lat_mode = 1;
    start_miss($urandom, 1'b0, '0, '0, $urandom, s);
    wait_resp("varlat_clean", s, -1);
    start_miss(32'h0000_4444, 1'b1, 32'hFFFF_FFC0, rand_line(), $urandom, s);
    wait_resp("varlat_dirty", s, -1);
    lat_mode = 0;

    start_miss(32'h0000_3000, 1'b1, 32'h0000_9000, rand_line(), $urandom, s);
    n = 0;
    while (wr_cnt < 6 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("rst_mid_wb_reached", LW'(wr_cnt >= 6), LW'(1));
    rst        = 1'b1;
    i_miss_req = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wr_exp_q.delete();
    rd_exp_q.delete();
    line_exp_q.delete();
    rsp_q.delete();
    check_eq("abort_req", LW'(o_mem_req), LW'(0));
    check_eq("abort_we", LW'(o_mem_we), LW'(0));
    check_eq("abort_addr", LW'(o_mem_addr), LW'(0));
    check_eq("abort_wdata", LW'(o_mem_wdata), LW'(0));
    check_eq("abort_busy", LW'(o_busy), LW'(0));
    check_eq("abort_resp", LW'(o_memory_response), LW'(0));
    check_eq("abort_line", o_memory_line, LW'(0));

    start_miss(32'h0000_2000, 1'b0, '0, '0, $urandom, s);
    wait_resp("after_abort", s, 18);

    resp_cnt = 0;
    @(negedge clk);
    spur = 1'b1;
    repeat (4) @(negedge clk);
    spur = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("spurious_line", o_memory_line, last_line);
    check_eq("spurious_resp", LW'(resp_cnt), LW'(0));
    check_eq("spurious_busy", LW'(o_busy), LW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
